// File: rtl/mm_mig_bridge.sv
// mm_mig_bridge
//   Bridges the cache subsystem's main-memory port to a Xilinx MIG UI
//   (native app_* interface) driving a 16-bit DDR3 device in BL8 mode.
//   Each transaction moves one 128-bit line (8 beats x 16 bit).
//   At most one transaction is outstanding at any time.
//
// Ports
//   clock, reset          ui_clk domain clock, asynchronous active-low reset
//   init_calib_complete   MIG calibration done; gates new request acceptance
//   req_*                 request channel (valid/ready), tag, byte address,
//                         direction and write data
//   res_*                 single-cycle read response pulse with tag, line
//                         address and data (no backpressure)
//   app_addr/cmd/en/rdy   MIG command channel
//   app_wdf_*             MIG write-data channel (single BL8 beat per write)
//   app_rd_data*          MIG read-data channel
module mm_mig_bridge #(
    parameter int PADDR_WIDTH    = 32,
    parameter int MIG_ADDR_WIDTH = 28,
    parameter int ID_WIDTH       = 4,
    parameter int DATA_WIDTH     = 128
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      init_calib_complete,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ID_WIDTH-1:0]       req_id,
    input  logic [PADDR_WIDTH-1:0]    req_paddr,
    input  logic                      req_is_write,
    input  logic [DATA_WIDTH-1:0]     req_data,

    output logic                      res_valid,
    output logic [ID_WIDTH-1:0]       res_id,
    output logic [PADDR_WIDTH-1:0]    res_paddr,
    output logic [DATA_WIDTH-1:0]     res_data,

    output logic [MIG_ADDR_WIDTH-1:0] app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    input  logic                      app_rdy,
    output logic [DATA_WIDTH-1:0]     app_wdf_data,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    input  logic                      app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]     app_rd_data,
    input  logic                      app_rd_data_valid,
    input  logic                      app_rd_data_end
);

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_CMD,
        READ_WAIT
    } state_t;

    state_t                    state;
    logic [ID_WIDTH-1:0]       id_q;
    logic [PADDR_WIDTH-1:0]    paddr_q;
    logic [MIG_ADDR_WIDTH-1:0] mig_addr;
    logic                      accept;
    logic                      cmd_done;
    logic                      wdf_done;
    logic                      paddr_lsb_unused;

    // Byte address -> 16-bit word address (>> 1), BL8 aligned (low 3 bits 0).
    // Word bits [MIG_ADDR_WIDTH-1:3] are byte bits [MIG_ADDR_WIDTH:4].
    assign mig_addr         = {req_paddr[MIG_ADDR_WIDTH:4], 3'b000};
    assign paddr_lsb_unused = ^req_paddr[3:0];

    // Reset is folded in so req_ready reads 0 while reset is held.
    assign req_ready = (state == IDLE) && init_calib_complete && reset;
    assign accept    = req_valid && req_ready;

    // In WRITE the valid itself serves as the "not yet done" flag for each
    // channel: a handshake is complete once its valid has dropped, or it
    // completes on this edge.
    assign cmd_done = !app_en || app_rdy;
    assign wdf_done = !app_wdf_wren || app_wdf_rdy;

    assign app_wdf_end = app_wdf_wren;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            id_q         <= '0;
            paddr_q      <= '0;
            res_valid    <= 1'b0;
            res_id       <= '0;
            res_paddr    <= '0;
            res_data     <= '0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_wren <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q     <= req_id;
                        paddr_q  <= {req_paddr[PADDR_WIDTH-1:4], 4'b0000};
                        app_addr <= mig_addr;
                        app_en   <= 1'b1;
                        if (req_is_write) begin
                            app_cmd      <= CMD_WRITE;
                            app_wdf_data <= req_data;
                            app_wdf_wren <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            app_cmd <= CMD_READ;
                            state   <= READ_CMD;
                        end
                    end
                end
                WRITE: begin
                    if (app_rdy)
                        app_en <= 1'b0;
                    if (app_wdf_rdy)
                        app_wdf_wren <= 1'b0;
                    if (cmd_done && wdf_done)
                        state <= IDLE;
                end
                READ_CMD: begin
                    if (app_rdy) begin
                        app_en <= 1'b0;
                        state  <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    // Data without the end marker is a protocol error: ignore it.
                    if (app_rd_data_valid && app_rd_data_end) begin
                        res_valid <= 1'b1;
                        res_id    <= id_q;
                        res_paddr <= paddr_q;
                        res_data  <= app_rd_data;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_mig_bridge.sv
module tb_mm_mig_bridge;

    logic         clock;
    logic         reset;
    logic         init_calib_complete;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_id;
    logic [31:0]  req_paddr;
    logic         req_is_write;
    logic [127:0] req_data;
    logic         res_valid;
    logic [3:0]   res_id;
    logic [31:0]  res_paddr;
    logic [127:0] res_data;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;

    mm_mig_bridge #(
        .PADDR_WIDTH   (32),
        .MIG_ADDR_WIDTH(28),
        .ID_WIDTH      (4),
        .DATA_WIDTH    (128)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .init_calib_complete(init_calib_complete),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_id             (req_id),
        .req_paddr          (req_paddr),
        .req_is_write       (req_is_write),
        .req_data           (req_data),
        .res_valid          (res_valid),
        .res_id             (res_id),
        .res_paddr          (res_paddr),
        .res_data           (res_data),
        .app_addr           (app_addr),
        .app_cmd            (app_cmd),
        .app_en             (app_en),
        .app_rdy            (app_rdy),
        .app_wdf_data       (app_wdf_data),
        .app_wdf_wren       (app_wdf_wren),
        .app_wdf_end        (app_wdf_end),
        .app_wdf_rdy        (app_wdf_rdy),
        .app_rd_data        (app_rd_data),
        .app_rd_data_valid  (app_rd_data_valid),
        .app_rd_data_end    (app_rd_data_end)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model. A transaction is accepted when the
    // bridge is free and calibrated; it owes a command handshake (and for
    // writes a data handshake). A write finishes once both are done; a read
    // finishes when end-marked data arrives after its command was taken,
    // producing one response on that edge.
    // ------------------------------------------------------------------
    bit           m_busy, m_is_wr, m_cmd_pend, m_wdf_pend, m_res_valid;
    logic [2:0]   m_cmd;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata, m_res_data;
    logic [3:0]   m_id, m_res_id;
    logic [31:0]  m_paddr, m_res_paddr, m_word;

    always @(posedge clock) begin
        if (!reset) begin
            m_busy = 0; m_is_wr = 0; m_cmd_pend = 0; m_wdf_pend = 0; m_res_valid = 0;
            m_res_id = '0; m_res_paddr = '0; m_res_data = '0;
        end else begin
            m_res_valid = 0;
            if (m_busy && m_is_wr) begin
                if (app_rdy)     m_cmd_pend = 0;
                if (app_wdf_rdy) m_wdf_pend = 0;
                if (!m_cmd_pend && !m_wdf_pend) m_busy = 0;
            end else if (m_busy && m_cmd_pend) begin
                if (app_rdy) m_cmd_pend = 0;
            end else if (m_busy) begin
                if (app_rd_data_valid && app_rd_data_end) begin
                    m_res_valid = 1;
                    m_res_id    = m_id;
                    m_res_paddr = m_paddr & ~32'hF;
                    m_res_data  = app_rd_data;
                    m_busy      = 0;
                end
            end else if (init_calib_complete && req_valid) begin
                m_busy     = 1;
                m_is_wr    = req_is_write;
                m_cmd_pend = 1;
                m_wdf_pend = req_is_write;
                m_cmd      = req_is_write ? 3'b000 : 3'b001;
                m_word     = req_paddr / 2;
                m_addr     = m_word[27:0] & ~28'h7;
                m_wdata    = req_data;
                m_id       = req_id;
                m_paddr    = req_paddr;
            end
        end
    end

    int unsigned dut_hs = 0;
    int unsigned res_pulses = 0;

    // Single compare process: every negedge, all outputs against the model.
    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_id", res_id, 0);
            chk("rst_res_paddr", res_paddr, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_app_en", app_en, 0);
            chk("rst_app_cmd", app_cmd, 0);
            chk("rst_app_addr", app_addr, 0);
            chk("rst_wdf_wren", app_wdf_wren, 0);
            chk("rst_wdf_end", app_wdf_end, 0);
            chk("rst_wdf_data", app_wdf_data, 0);
        end else begin
            chk("req_ready", req_ready, !m_busy && init_calib_complete);
            chk("app_en", app_en, m_cmd_pend);
            if (m_cmd_pend) begin
                chk("app_cmd", app_cmd, m_cmd);
                chk("app_addr", app_addr, m_addr);
            end
            chk("app_wdf_wren", app_wdf_wren, m_wdf_pend);
            chk("app_wdf_end", app_wdf_end, m_wdf_pend);
            if (m_wdf_pend)
                chk("app_wdf_data", app_wdf_data, m_wdata);
            chk("res_valid", res_valid, m_res_valid);
            chk("res_id", res_id, m_res_id);
            chk("res_paddr", res_paddr, m_res_paddr);
            chk("res_data", res_data, m_res_data);
            if (app_en && app_rdy) dut_hs++;
            if (res_valid) res_pulses++;
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input bit v, input bit wr, input logic [3:0] id,
                           input logic [31:0] pa, input logic [127:0] d);
        req_valid = v; req_is_write = wr; req_id = id; req_paddr = pa; req_data = d;
    endtask

    task automatic return_read(input logic [127:0] d);
        app_rd_data = d; app_rd_data_valid = 1; app_rd_data_end = 1;
        step();
        app_rd_data_valid = 0; app_rd_data_end = 0;
    endtask

    int unsigned hs0, rp0;
    logic [127:0] rd_pat, wr_pat;

    initial begin
        rd_pat = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        wr_pat = {8{16'hAA55}};
        reset = 0; init_calib_complete = 0;
        set_req(0, 0, 0, 0, 0);
        app_rdy = 0; app_wdf_rdy = 0;
        app_rd_data = '0; app_rd_data_valid = 0; app_rd_data_end = 0;
        step(); step();
        @(negedge clock);
        chk("reset_app_en", app_en, 0);
        step();
        reset = 1;

        // Calibration gate, then basic read.
        set_req(1, 0, 4'd3, 32'h8000_0040, '0);
        app_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("calib_req_ready", req_ready, 0);
            chk("calib_app_en", app_en, 0);
            step();
        end
        init_calib_complete = 1;
        step();
        set_req(0, 0, 0, 0, 0);
        @(negedge clock);
        chk("rd_app_en", app_en, 1);
        chk("rd_app_addr", app_addr, 28'h000_0020);
        chk("rd_app_cmd", app_cmd, 3'b001);
        step();
        step(); step();
        return_read(rd_pat);
        @(negedge clock);
        chk("rd_res_valid", res_valid, 1);
        chk("rd_res_id", res_id, 4'd3);
        chk("rd_res_paddr", res_paddr, 32'h8000_0040);
        chk("rd_res_data", res_data, rd_pat);
        chk("rd_req_ready", req_ready, 1);
        step();
        @(negedge clock);
        chk("rd_res_pulse_once", res_valid, 0);
        chk("rd_res_data_hold", res_data, rd_pat);

        // Write, data before command.
        rp0 = res_pulses;
        app_rdy = 0; app_wdf_rdy = 1;
        set_req(1, 1, 4'd9, 32'h0000_0010, wr_pat);
        step();
        set_req(0, 0, 0, 0, 0);
        @(negedge clock);
        chk("wr_wdf_data", app_wdf_data, wr_pat);
        step();
        @(negedge clock);
        chk("wr_wren_dropped", app_wdf_wren, 0);
        chk("wr_app_en_held", app_en, 1);
        chk("wr_app_addr", app_addr, 28'h8);
        chk("wr_app_cmd", app_cmd, 3'b000);
        chk("wr_req_ready_busy", req_ready, 0);
        step(); step(); step();
        app_rdy = 1;
        step();
        @(negedge clock);
        chk("wr_app_en_dropped", app_en, 0);
        chk("wr_req_ready_back", req_ready, 1);
        chk("wr_no_response", res_pulses - rp0, 0);

        // Write with both handshakes in the first WRITE cycle, then a read.
        app_rdy = 1; app_wdf_rdy = 1;
        set_req(1, 1, 4'd1, 32'h0000_0020, ~wr_pat);
        step();
        set_req(1, 0, 4'd5, 32'h0000_0030, '0);
        @(negedge clock);
        chk("wr2_req_ready_busy", req_ready, 0);
        step();
        @(negedge clock);
        chk("wr2_req_ready_back", req_ready, 1);
        step();
        set_req(0, 0, 0, 0, 0);
        @(negedge clock);
        chk("b2b_app_cmd", app_cmd, 3'b001);
        chk("b2b_app_addr", app_addr, 28'h18);
        step();
        return_read(~rd_pat);
        @(negedge clock);
        chk("b2b_res_id", res_id, 4'd5);
        chk("b2b_res_data", res_data, ~rd_pat);

        // Stalled read command.
        app_rdy = 0;
        set_req(1, 0, 4'd7, 32'h0000_1234, '0);
        step();
        set_req(0, 0, 0, 0, 0);
        hs0 = dut_hs;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            chk("stall_app_en", app_en, 1);
            chk("stall_app_cmd", app_cmd, 3'b001);
            chk("stall_app_addr", app_addr, 28'h918);
            step();
        end
        app_rdy = 1;
        step();
        app_rdy = 0;
        step(); step();
        chk("stall_one_handshake", dut_hs - hs0, 1);
        // End-less data is ignored; the read still waits.
        app_rd_data = rd_pat; app_rd_data_valid = 1; app_rd_data_end = 0;
        step();
        app_rd_data_valid = 0;
        @(negedge clock);
        chk("noend_ignored", res_valid, 0);
        return_read(rd_pat ^ 128'hF0);
        @(negedge clock);
        chk("stall_res_paddr", res_paddr, 32'h0000_1230);

        // Reset while waiting for read data, then a stray data beat.
        app_rdy = 1;
        set_req(1, 0, 4'd2, 32'h0000_0100, '0);
        step();
        set_req(0, 0, 0, 0, 0);
        step(); step();
        reset = 0;
        @(negedge clock);
        chk("midrst_app_en", app_en, 0);
        step(); step();
        reset = 1;
        rp0 = res_pulses;
        return_read(rd_pat);
        step();
        chk("stray_no_response", res_pulses - rp0, 0);
        set_req(1, 0, 4'd4, 32'h0000_0200, '0);
        step();
        set_req(0, 0, 0, 0, 0);
        step();
        return_read(~rd_pat);
        @(negedge clock);
        chk("post_rst_res_valid", res_valid, 1);
        chk("post_rst_res_id", res_id, 4'd4);

        // Randomized traffic with random MIG readiness and stray beats.
        for (int i = 0; i < 3000; i++) begin
            reset               = ($urandom_range(0, 399) != 0);
            init_calib_complete = ($urandom_range(0, 15) != 0);
            set_req($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom),
                    $urandom, {$urandom, $urandom, $urandom, $urandom});
            app_rdy           = $urandom_range(0, 2) != 0;
            app_wdf_rdy       = $urandom_range(0, 2) != 0;
            app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
            app_rd_data_valid = $urandom_range(0, 3) == 0;
            app_rd_data_end   = $urandom_range(0, 4) != 0;
            step();
        end
        reset = 1;
        set_req(0, 0, 0, 0, 0);
        app_rd_data_valid = 0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mm_mig_bridge.md
Name: mm_mig_bridge

Overview:
- Sits directly downstream of the cache subsystem's main-memory port.
- Converts one 128-bit request per transaction into Xilinx MIG UI (native app_*) command and write-data handshakes, targeting a 16-bit DDR3 device with burst length 8 (BL8 × 16 bit = 128 bit).
- Read data is returned as a single-cycle response pulse.
- At most one transaction is in flight.

Parameters:
- PADDR_WIDTH, 32, physical address width of incoming requests.
- MIG_ADDR_WIDTH, 28, width of app_addr (16-bit word address).
- ID_WIDTH, 4, request/response tag width.
- DATA_WIDTH, 128, request/response and MIG UI data width; fixed to 128.

Ports:
- clock  in  1  system clock (MIG ui_clk domain)
- reset  in  1  asynchronous, active-low reset
- init_calib_complete  in  1  MIG calibration done
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts request this cycle
- req_id  in  ID_WIDTH  request tag
- req_paddr  in  PADDR_WIDTH  byte address, 16-byte aligned
- req_is_write  in  1  1 = write, 0 = read
- req_data  in  DATA_WIDTH  write data, little-endian (byte 0 in bits [7:0])
- res_valid  out  1  read response pulse
- res_id  out  ID_WIDTH  tag of returned read
- res_paddr  out  PADDR_WIDTH  address of returned read
- res_data  out  DATA_WIDTH  read data
- app_addr  out  MIG_ADDR_WIDTH  MIG command address
- app_cmd  out  3  3'b000 = write, 3'b001 = read
- app_en  out  1  command valid
- app_rdy  in  1  MIG accepts command
- app_wdf_data  out  DATA_WIDTH  write data
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  last beat; always equal to app_wdf_wren
- app_wdf_rdy  in  1  MIG accepts write data
- app_rd_data  in  DATA_WIDTH  read data
- app_rd_data_valid  in  1  read data valid
- app_rd_data_end  in  1  last read beat

Behaviour:
- Reset (reset == 0, async):
  - State goes to IDLE.
  - All outputs are 0: req_ready, res_*, app_en, app_wdf_wren, app_wdf_end, app_addr, app_cmd, app_wdf_data.
  - Any in-flight transaction is abandoned without a response. A late app_rd_data_valid arriving in IDLE after reset is ignored.
- States: IDLE, WRITE, READ_CMD, READ_WAIT.
- req_ready:
  - Combinational: req_ready = (state == IDLE) && init_calib_complete.
  - Acceptance occurs on the edge where req_valid && req_ready.
  - On acceptance, id, paddr, is_write and data are registered.
- Address mapping:
  - app_addr = {req_paddr >> 1}[MIG_ADDR_WIDTH-1:0], with bits [2:0] forced to 0 (BL8 aligned).
  - req_paddr[3:0] is ignored.
  - res_paddr returns the registered req_paddr with bits [3:0] cleared.
- IDLE:
  - Write accepted -> WRITE, with app_en = 1, app_cmd = 000 and app_wdf_wren = app_wdf_end = 1 asserted from the next cycle.
  - Read accepted -> READ_CMD, with app_en = 1 and app_cmd = 001.
- WRITE:
  - Command and data handshakes are independent; each tracks its own done flag.
  - app_en drops the cycle after app_en && app_rdy.
  - app_wdf_wren drops the cycle after app_wdf_wren && app_wdf_rdy.
  - Either order is allowed, including both in the same cycle, or data before command.
  - When both flags are set -> IDLE.
  - Minimum write occupancy is 1 cycle in WRITE (both handshakes in the first cycle).
  - Writes generate no response.
- READ_CMD:
  - app_en is held with app_addr stable until app_rdy.
  - On handshake -> READ_WAIT, with app_en = 0.
- READ_WAIT:
  - On app_rd_data_valid && app_rd_data_end, app_rd_data is captured.
  - res_valid = 1 for exactly one cycle (the next cycle), together with res_id, res_paddr and res_data; state -> IDLE on the same edge.
  - res_valid therefore coincides with req_ready becoming 1 again.
  - res_valid has no backpressure; the consumer must accept it.
  - app_rd_data_valid without app_rd_data_end is a protocol error: data is ignored and the block stays in READ_WAIT.
- res_data and res_id hold their last value when res_valid = 0.
- init_calib_complete falling mid-transaction does not abort the transaction; it only gates new acceptance.
- app_cmd, app_addr and app_wdf_data remain stable while the corresponding valid is high and not yet accepted.
- app_rd_data_valid in IDLE, WRITE or READ_CMD is ignored.

Test Plan:
- Calibration gate: hold init_calib_complete = 0 with req_valid = 1 for 10 cycles -> req_ready = 0 and app_en = 0 throughout; raise it -> accepted next edge.
- Basic read: paddr = 0x8000_0040, id = 3; app_rdy = 1; return app_rd_data = 0x0123…CDEF three cycles later -> app_addr = 0x0000020, app_cmd = 001, then one res_valid pulse with id = 3, paddr = 0x8000_0040 and matching data.
- Write, data-first ordering: paddr = 0x10, data = 0xAA…55; app_rdy = 0 for 4 cycles, app_wdf_rdy = 1 -> wdf accepted at cycle 1; app_en held with app_addr = 0x8 until app_rdy; no res_valid; req_ready returns after the cmd handshake.
- Write, same-cycle handshakes: both ready from the start -> state is back in IDLE after 1 cycle in WRITE; back-to-back read accepted immediately.
- Stalled read command: app_rdy = 0 for 7 cycles -> app_en, app_cmd and app_addr are stable all 7 cycles; exactly one command handshake occurs.
- Reset mid-read: assert reset in READ_WAIT, release, then inject a stray app_rd_data_valid -> all outputs are 0 during reset; no res_valid afterward; next read completes normally.
